// File: rtl/fetch_stage.sv
// Instruction fetch with req/ack memory port and IF/ID register; one-entry skid buffer absorbs a word
// returned while Decode stalls. Zero-wait memory gives one instruction per cycle; redirects flush IF/ID.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic [31:0] instruction,
  output logic [31:0] pcPlus4,
  output logic        ifidValid
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] req_addr, req_addr_nxt;
  logic [31:0] instr_nxt, pc4_nxt;
  logic        vld_nxt;
  logic [31:0] buf_instr, buf_instr_nxt;
  logic [31:0] buf_pc4, buf_pc4_nxt;
  logic        accept;
  logic [31:0] req_pc4;
  logic [31:0] redirect_pc;
  logic        unused_low_bits;

  assign accept          = !stall || !ifidValid;
  assign req_pc4         = req_addr + 32'd4;
  assign redirect_pc     = {redirectPc[31:2], 2'b00};
  assign unused_low_bits = ^redirectPc[1:0];
  assign imemReq         = (state == REQ) || (state == DRAIN);
  assign imemAddr        = req_addr;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      instruction <= '0;
      pcPlus4     <= '0;
      ifidValid   <= 1'b0;
      buf_instr   <= '0;
      buf_pc4     <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      req_addr    <= req_addr_nxt;
      instruction <= instr_nxt;
      pcPlus4     <= pc4_nxt;
      ifidValid   <= vld_nxt;
      buf_instr   <= buf_instr_nxt;
      buf_pc4     <= buf_pc4_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    req_addr_nxt  = req_addr;
    instr_nxt     = instruction;
    pc4_nxt       = pcPlus4;
    vld_nxt       = ifidValid;
    buf_instr_nxt = buf_instr;
    buf_pc4_nxt   = buf_pc4;
    // Whenever nothing loads, an unstalled IF/ID turns into a bubble.
    if (!stall) begin
      instr_nxt = '0;
      vld_nxt   = 1'b0;
    end
    if (redirect) begin
      instr_nxt     = '0;
      pc4_nxt       = '0;
      vld_nxt       = 1'b0;
      buf_instr_nxt = '0;
      buf_pc4_nxt   = '0;
      pc_nxt        = redirect_pc;
      // An unanswered request must be drained before the new address can go out.
      if (state == DRAIN || (state == REQ && !imemAck)) begin
        state_nxt = DRAIN;
      end else begin
        state_nxt    = REQ;
        req_addr_nxt = redirect_pc;
      end
    end else begin
      case (state)
        IDLE: begin
          state_nxt    = REQ;
          req_addr_nxt = pc;
        end
        REQ: begin
          if (imemAck) begin
            pc_nxt = req_pc4;
            if (accept) begin
              instr_nxt    = imemData;
              pc4_nxt      = req_pc4;
              vld_nxt      = 1'b1;
              req_addr_nxt = req_pc4;
            end else begin
              buf_instr_nxt = imemData;
              buf_pc4_nxt   = req_pc4;
              state_nxt     = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_nxt    = buf_instr;
            pc4_nxt      = buf_pc4;
            vld_nxt      = 1'b1;
            req_addr_nxt = pc;
            state_nxt    = REQ;
          end
        end
        DRAIN: begin
          if (imemAck) begin
            req_addr_nxt = pc;
            state_nxt    = REQ;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: behavioural memory with programmable latency and a queue of
// expected IF/ID entries filled on each accepted memory response.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rstN;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic [31:0] instruction;
  logic [31:0] pcPlus4;
  logic        ifidValid;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rstN(rstN), .stall(stall), .redirect(redirect), .redirectPc(redirectPc),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
    .instruction(instruction), .pcPlus4(pcPlus4), .ifidValid(ifidValid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  ent_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          lat;
  int          mem_cnt;
  logic [31:0] exp_instr, exp_pc4, exp_fetch, drain_addr;
  logic        exp_valid, drain_expected;

  function automatic logic [31:0] memw(input logic [31:0] a);
    if (a == 32'h0) return 32'h0443_0004;
    if (a == 32'h4) return 32'h1CB6_2C0A;
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_instr      = '0;
    exp_pc4        = '0;
    exp_valid      = 1'b0;
    exp_fetch      = 32'h0;
    drain_expected = 1'b0;
    drain_addr     = '0;
    mem_cnt        = 0;
    imemAck        = 1'b0;
    imemData       = '0;
  endtask

  // Close out the current cycle in the model, advance one clock, then compare IF/ID.
  task automatic cycle();
    ent_t e;
    if (imemReq) begin
      if (drain_expected) check("drain_addr", imemAddr, drain_addr);
      else check("req_addr", imemAddr, exp_fetch);
    end
    if (redirect) begin
      if (imemReq && !imemAck && !drain_expected) begin
        drain_expected = 1'b1;
        drain_addr     = exp_fetch;
      end
      exp_fetch = redirectPc & 32'hFFFF_FFFC;
      q.delete();
    end else if (imemReq && imemAck) begin
      if (drain_expected) begin
        drain_expected = 1'b0;
      end else begin
        q.push_back({memw(exp_fetch), exp_fetch + 32'd4});
        exp_fetch = exp_fetch + 32'd4;
      end
    end
    if (redirect) begin
      exp_instr = '0; exp_pc4 = '0; exp_valid = 1'b0;
    end else if (q.size() > 0 && (!stall || !exp_valid)) begin
      e = q.pop_front();
      exp_instr = e.instr; exp_pc4 = e.pc4; exp_valid = 1'b1;
    end else if (!stall) begin
      exp_instr = '0; exp_valid = 1'b0;
    end
    if (imemReq && imemAck) mem_cnt = 0;
    else if (imemReq) mem_cnt++;
    else mem_cnt = 0;

    @(posedge clk);
    #1;
    imemAck  = imemReq && (mem_cnt >= lat);
    imemData = imemAck ? memw(imemAddr) : 32'hBAD0_BAD0;
    @(negedge clk);
    check("instruction", instruction, exp_instr);
    check("pcPlus4", pcPlus4, exp_pc4);
    check("ifidValid", {31'h0, ifidValid}, {31'h0, exp_valid});
  endtask

  initial begin
    rstN = 1'b0; stall = 1'b0; redirect = 1'b0; redirectPc = '0; lat = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_req", {31'h0, imemReq}, 32'h0);
    check("rst_addr", imemAddr, 32'h0);
    check("rst_instr", instruction, 32'h0);
    check("rst_pc4", pcPlus4, 32'h0);
    check("rst_valid", {31'h0, ifidValid}, 32'h0);

    // Reset release and zero-wait streaming
    rstN = 1'b1;
    check("idle_req", {31'h0, imemReq}, 32'h0);
    cycle();
    check("first_req", {31'h0, imemReq}, 32'h1);
    check("first_addr", imemAddr, 32'h0);
    cycle();
    check("word0", instruction, 32'h0443_0004);
    check("word0_pc4", pcPlus4, 32'h4);
    cycle();
    check("word1", instruction, 32'h1CB6_2C0A);
    check("word1_pc4", pcPlus4, 32'h8);
    repeat (3) cycle();

    // Three-cycle stall: one word parks in the skid buffer
    stall = 1'b1;
    cycle();
    check("hold_req", {31'h0, imemReq}, 32'h0);
    repeat (2) cycle();
    stall = 1'b0;
    repeat (4) cycle();

    // Redirect while a slow response is outstanding
    lat = 3;
    cycle();
    redirect = 1'b1; redirectPc = 32'h0000_0103;
    cycle();
    check("drain_req", {31'h0, imemReq}, 32'h1);
    redirect = 1'b0;
    repeat (9) cycle();
    lat = 0;
    repeat (4) cycle();

    // Redirect together with stall while the skid buffer is full
    stall = 1'b1;
    cycle();
    redirect = 1'b1; redirectPc = 32'h0000_0200;
    cycle();
    check("flush_instr", instruction, 32'h0);
    check("flush_valid", {31'h0, ifidValid}, 32'h0);
    redirect = 1'b0;
    cycle();
    stall = 1'b0;
    repeat (3) cycle();

    // Redirect to the top word, fetch wraps to zero
    redirect = 1'b1; redirectPc = 32'hFFFF_FFFC;
    cycle();
    redirect = 1'b0;
    cycle();
    check("wrap_pc4", pcPlus4, 32'h0);
    check("wrap_valid", {31'h0, ifidValid}, 32'h1);
    cycle();
    check("wrap_next", instruction, 32'h0443_0004);
    repeat (2) cycle();

    // Reset asserted while draining
    lat = 3;
    cycle();
    redirect = 1'b1; redirectPc = 32'h0000_0300;
    cycle();
    redirect = 1'b0;
    cycle();
    rstN = 1'b0;
    #1;
    check("arst_req", {31'h0, imemReq}, 32'h0);
    check("arst_addr", imemAddr, 32'h0);
    check("arst_instr", instruction, 32'h0);
    check("arst_pc4", pcPlus4, 32'h0);
    check("arst_valid", {31'h0, ifidValid}, 32'h0);
    model_reset();
    lat = 0;
    repeat (2) cycle();
    rstN = 1'b1;
    check("rel_idle", {31'h0, imemReq}, 32'h0);
    cycle();
    check("rel_req", {31'h0, imemReq}, 32'h1);
    check("rel_addr", imemAddr, 32'h0);
    cycle();
    check("rel_word0", instruction, 32'h0443_0004);
    repeat (3) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
